muldiv_unit: RTL and testbench

- Iterative multi-cycle multiply/divide engine for the MIPS pipeline; owns the HI/LO registers.
- Sits in the EX stage alongside the ALU.
- Acts as the stall-request source for the pipeline stall/forwarding controller: it raises `stall_req`, and the controller converts that into PC/IF-ID hold and ID-EX bubble.
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO, and serves MFHI/MFLO reads.

---
 rtl/muldiv_unit.sv | 88 ++++++++
 tb/tb_muldiv_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide engine owning HI/LO, with pipeline stall request
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             rd_hilo,
  input  logic             cancel,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_div, r_neg_q, r_neg_r;
  logic               w_sgn;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_sum, w_rem_sh;
  logic [WIDTH-1:0]   w_rem_sub;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_mul_nxt, w_div_nxt, w_prod;
  logic [WIDTH-1:0]   w_q, w_r;
  assign w_sgn     = ~op[0];
  assign w_a_mag   = (w_sgn & A[WIDTH-1]) ? -A : A;
  assign w_b_mag   = (w_sgn & B[WIDTH-1]) ? -B : B;
  // r_acc low half holds the multiplier/dividend, consumed one bit per step
  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};
  assign w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge      = w_rem_sh >= {1'b0, r_b};
  assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_b;
  assign w_div_nxt = {w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], w_ge};
  assign w_prod    = r_neg_q ? -r_acc : r_acc;
  assign w_q       = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_r       = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  assign stall_req = busy & (start | rd_hilo) | (r_state == FIX & rd_hilo);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else if (r_state == IDLE) begin
      if (start & ~cancel) begin
        if (op == 3'b100) hi <= A;
        if (op == 3'b101) lo <= A;
        if (~op[2]) begin
          r_state <= RUN;
          busy    <= 1'b1;
          r_cnt   <= CNT_W'(WIDTH-1);
          r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
          r_b     <= w_b_mag;
          r_div   <= op[1];
          // a zero divisor leaves the all-ones quotient unsigned
          r_neg_q <= w_sgn & (A[WIDTH-1] ^ B[WIDTH-1]) & (|B);
          r_neg_r <= w_sgn & A[WIDTH-1];
        end
      end
    end else if (cancel) begin
      r_state <= IDLE;
      busy    <= 1'b0;
    end else if (r_state == RUN) begin
      r_acc <= r_div ? w_div_nxt : w_mul_nxt;
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == '0) r_state <= FIX;
    end else begin
      r_state <= IDLE;
      busy    <= 1'b0;
      hi      <= r_div ? w_r : w_prod[2*WIDTH-1:WIDTH];
      lo      <= r_div ? w_q : w_prod[WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven and scoreboarded checks of muldiv_unit, plus cancel/reset/busy corner cases
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst, start, cancel, rd_hilo;
  logic [2:0]  op;
  logic [31:0] A, B, hi, lo;
  logic        busy, stall_req;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] exp;
    logic        rdh;
  } vec_t;
  vec_t vt[10];

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .rd_hilo(rd_hilo), .cancel(cancel), .busy(busy), .stall_req(stall_req),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int sa, sbv;
    sa = a;
    sbv = b;
    if (o == 3'd0) begin
      p = longint'(sa) * longint'(sbv);
      return p;
    end
    if (o == 3'd1) return {32'd0, a} * {32'd0, b};
    if (b == 0) return {a, 32'hFFFFFFFF};
    if (o == 3'd3) return {a % b, a / b};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
    return {32'(sa % sbv), 32'(sa / sbv)};
  endfunction

  // Issue one op, optionally poke an ignored start at busy cycle poke, then check latency, stall and result
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input logic rdh, input int poke, input string name);
    int n;
    logic stall_bad;
    logic [63:0] e;
    @(negedge clk);
    op = o; A = a; B = b; start = 1'b1; rd_hilo = rdh;
    sb.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    stall_bad = 1'b0;
    while (busy && n < 100) begin
      if (rdh && !stall_req) stall_bad = 1'b1;
      if (n == poke && poke > 0) begin
        op = 3'd3; A = 32'd9; B = 32'd3; start = 1'b1;
        #1 chk({name, " stall on start while busy"}, 64'(stall_req), 64'd1);
      end else start = 1'b0;
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    chk({name, " busy cycles"}, 64'(n), 64'd33);
    if (rdh) begin
      chk({name, " stall during busy"}, 64'(stall_bad), 64'd0);
      chk({name, " stall after busy"}, 64'(stall_req), 64'd0);
    end
    rd_hilo = 1'b0;
    e = sb.pop_front();
    chk({name, " hi:lo"}, {hi, lo}, e);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    vt[0] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0};
    vt[1] = '{3'd0, 32'hFFFFFFFD, 32'd7,        64'hFFFFFFFF_FFFFFFEB, 1'b1};
    vt[2] = '{3'd2, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 1'b0};
    vt[3] = '{3'd3, 32'd100,      32'd7,        64'h00000002_0000000E, 1'b0};
    vt[4] = '{3'd3, 32'h1234,     32'd0,        64'h00001234_FFFFFFFF, 1'b1};
    vt[5] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0};
    vt[6] = '{3'd2, 32'hFFFFFFFB, 32'd0,        64'hFFFFFFFB_FFFFFFFF, 1'b0};
    vt[7] = '{3'd0, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0};
    vt[8] = '{3'd2, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0};
    vt[9] = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 1'b0};
    rst = 1'b1; start = 1'b0; cancel = 1'b0; rd_hilo = 1'b0; op = 3'd0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset stall", 64'(stall_req), 64'd0);
    chk("reset hi:lo", {hi, lo}, 64'd0);

    for (int i = 0; i < 10; i++)
      do_op(vt[i].op, vt[i].a, vt[i].b, vt[i].exp, vt[i].rdh, 0, $sformatf("vec%0d", i));

    for (int i = 0; i < 12; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      do_op(ro, ra, rb, model(ro, ra, rb), 1'b0, 0, $sformatf("rand%0d", i));
    end

    do_op(3'd1, 32'd6, 32'd7, 64'd42, 1'b0, 3, "start ignored while busy");

    // MTHI then MTLO back to back
    @(negedge clk);
    op = 3'd4; A = 32'hAAAA5555; start = 1'b1;
    @(negedge clk);
    chk("mthi hi", 64'(hi), 64'hAAAA5555);
    chk("mthi busy", 64'(busy), 64'd0);
    op = 3'd5; A = 32'h0F0F0F0F;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo hi:lo", {hi, lo}, 64'hAAAA5555_0F0F0F0F);
    chk("mtlo busy", 64'(busy), 64'd0);

    // cancel with start in IDLE drops the start
    op = 3'd4; A = 32'h12345678; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("idle cancel hi", 64'(hi), 64'hAAAA5555);
    chk("idle cancel busy", 64'(busy), 64'd0);

    // cancel on RUN cycle 10
    op = 3'd3; A = 32'd100; B = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("busy before cancel", 64'(busy), 64'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    chk("cancel hi:lo kept", {hi, lo}, 64'hAAAA5555_0F0F0F0F);
    chk("cancel busy stays low", 64'(busy), 64'd0);

    // reset during RUN with a start pulse that must be ignored
    op = 3'd0; A = 32'd2; B = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    op = 3'd0; A = 32'd5; B = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1; cancel = 1'b1;
    @(negedge clk);
    rst = 1'b0; cancel = 1'b0;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst hi:lo", {hi, lo}, 64'd0);
    chk("rst stall", 64'(stall_req), 64'd0);
    do_op(3'd1, 32'd6, 32'd7, 64'd42, 1'b1, 0, "multu after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
